axi_rd_burst_master: RTL
========================

// Module: axi_rd_burst_master
// PURPOSE
//  Parametrised AXI4 read master for the ysyx_22041071 core; successor to the single-beat read channel.
//  Accepts one read request (single or INCR/WRAP burst) from the cache/LSU and issues it on AR.
//  Streams each R beat out with backpressure, assembles the full burst into a line buffer for cache
//  refill, and returns accumulated response status. One outstanding transaction at a time.
// PARAMETERS
//  DATA_W     64  AXI data width in bits (power of 2, >= 32)
//  ADDR_W     64  address width
//  ID_W        4  AXI ID width
//  MAX_BEATS   8  max beats per burst = line-buffer depth (power of 2); req_len < MAX_BEATS
// PORTS
//  clk           in   1                 clock, rising edge
//  reset_n       in   1                 synchronous, active-low reset
//  req_valid     in   1                 request valid
//  req_ready     out  1                 request accepted when req_valid & req_ready
//  req_id        in   ID_W              transaction ID
//  req_addr      in   ADDR_W            byte address
//  req_len       in   8                 beats-1 (AXI ARLEN)
//  req_size      in   3                 bytes per beat = 2**req_size, <= DATA_W/8
//  req_wrap      in   1                 1: WRAP burst, 0: INCR
//  beat_valid    out  1                 registered beat output valid
//  beat_ready    in   1                 consumer ready for beat
//  beat_data     out  DATA_W            beat data; single narrow reads right-justified, zero-extended
//  beat_last     out  1                 final beat of burst
//  line_valid    out  1                 1-cycle pulse: whole burst in line_data
//  line_data     out  MAX_BEATS*DATA_W  assembled line, slot k at bits [k*DATA_W +: DATA_W]
//  line_resp     out  2                 worst response over burst (valid with line_valid)
//  m_arvalid/arready/arid/araddr/arlen/arsize/arburst  AXI AR channel (out/in/out...)
//  m_arprot/arcache/arqos/arregion/arlock/aruser       tied 0
//  m_rvalid/rready/rid/rdata/rresp/rlast               AXI R channel (in/out/in...)
// BEHAVIOUR
//  Reset: state IDLE; req_ready=1; m_arvalid, m_rready, beat_valid, beat_last, line_valid=0;
//    line_resp=0; all AR fields=0; line_data=0; beat counter=0.
//  FSM IDLE -> ADDR on request handshake; ADDR -> DATA on arvalid&arready;
//    DATA -> DONE on accepted R beat with rlast; DONE -> IDLE when beat_valid cleared (1 cycle min).
//  req_ready = (state==IDLE). All request fields latched at handshake; AR outputs driven only
//    from latched registers, stable while m_arvalid=1 (no dependence on live req_* inputs).
//  m_arvalid = (state==ADDR), asserted the cycle after acceptance (1-cycle req->AR latency).
//  araddr: single beat -> req_addr aligned down to 2**req_size; burst -> aligned down to DATA_W/8,
//    arsize=log2(DATA_W/8) for bursts, req_size for singles. arburst=WRAP(2'b10) if req_wrap else INCR(2'b01).
//  m_rready = (state==DATA) & (~beat_valid | beat_ready). Beat handshake loads beat output
//    register next cycle; beat_valid holds until beat_ready; no bubbles when beat_ready=1.
//  Narrow single read: beat_data = (rdata >> 8*addr[log2(DATA_W/8)-1:0]) masked to 2**req_size bytes.
//  Line slot for beat i: INCR -> i; WRAP -> (start_slot + i) mod (arlen+1), start_slot = addr word index.
//  line_resp = max(rresp) over beats. Force 2'b10 if rid != latched id, if rlast before beat arlen,
//    or if beat arlen arrives without rlast (then burst closes at that beat as if rlast).
//  Beat counter width log2(MAX_BEATS); never wraps because req_len < MAX_BEATS.
//  line_valid pulses in the cycle state enters DONE; line_data held until next request's first beat.
//  Request while busy: req_ready=0, ignored. Reset mid-burst: immediate return to IDLE, partial
//    line discarded, no line_valid; AXI side is reset simultaneously.
// STRUCTURE
//  Shared package/define file: AXI burst/resp encodings, AXI field widths, FSM state encodings.
//  One sub-module: axi_rd_beat_extract (combinational narrow-read shift/mask + line-slot index).
// TESTING
//  Single 8B read addr 0x8000_0010, rdata=0x1122334455667788, OKAY -> araddr 0x8000_0010, arlen 0,
//    beat_data 0x1122334455667788, beat_last=1, line_resp 0.
//  Narrow 2B read addr 0x..06, rdata=0xAABB_0000_0000_0000 -> beat_data 0x000..AABB, arsize 1.
//  INCR len=7 with beat_ready toggling 1/0 -> 8 beats in order, no loss/dup, line slots 0..7, one line_valid.
//  WRAP len=3 addr 0x..18 (slot 3) -> beats land in slots 3,0,1,2; arburst 2'b10.
//  Burst with beat 2 rresp=SLVERR, early rlast, or wrong rid -> line_resp 2'b10, FSM back to IDLE.
//  arready delayed 5 cycles with req_addr changed meanwhile -> araddr stable; reset_n low mid-burst -> IDLE, no line_valid.

Source files
------------

// File: rtl/axi_rd_burst_master_pkg.sv
// Shared AXI encodings, field widths and FSM states for the burst read master.
package axi_rd_burst_master_pkg;

  localparam int AXI_LEN_W    = 8;
  localparam int AXI_SIZE_W   = 3;
  localparam int AXI_BURST_W  = 2;
  localparam int AXI_RESP_W   = 2;
  localparam int AXI_PROT_W   = 3;
  localparam int AXI_CACHE_W  = 4;
  localparam int AXI_QOS_W    = 4;
  localparam int AXI_REGION_W = 4;
  localparam int AXI_USER_W   = 1;

  localparam logic [AXI_BURST_W-1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [AXI_BURST_W-1:0] AXI_BURST_WRAP = 2'b10;

  localparam logic [AXI_RESP_W-1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [AXI_RESP_W-1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_DONE = 2'd3
  } rd_state_e;

  // Response severity grows with the encoding, so the worst one is the numeric max.
  function automatic logic [AXI_RESP_W-1:0] resp_max(input logic [AXI_RESP_W-1:0] a,
                                                     input logic [AXI_RESP_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/axi_rd_burst_master_beat_extract.sv
// Combinational beat extraction: narrow-read lane shift/mask and line-buffer slot index.
module axi_rd_beat_extract
  import axi_rd_burst_master_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int MAX_BEATS = 8,
  localparam int OFF_W    = $clog2(DATA_W / 8),
  localparam int SLOT_W   = $clog2(MAX_BEATS)
) (
  input  logic [DATA_W-1:0]     rdata,
  input  logic [OFF_W-1:0]      byte_off,
  input  logic [AXI_SIZE_W-1:0] size,
  input  logic                  wrap,
  input  logic [SLOT_W-1:0]     start_slot,
  input  logic [SLOT_W-1:0]     beat_idx,
  input  logic [SLOT_W-1:0]     len,
  output logic [DATA_W-1:0]     data,
  output logic [SLOT_W-1:0]     slot
);

  logic [DATA_W-1:0] shifted_s;
  logic [DATA_W-1:0] mask_s;
  logic [10:0]       lane_bits_s;
  logic [SLOT_W-1:0] wrapped_s;

  // Bursts are always full width with a zero lane offset, so one path serves both cases.
  always_comb begin
    shifted_s   = rdata >> {byte_off, 3'b000};
    lane_bits_s = 11'd8 << size;
    mask_s      = ~({DATA_W{1'b1}} << lane_bits_s);
    data        = shifted_s & mask_s;
    // WRAP lengths are powers of two, so masking with arlen is the modulo.
    wrapped_s   = (start_slot + beat_idx) & len;
    slot        = wrap ? wrapped_s : beat_idx;
  end

endmodule

// File: rtl/axi_rd_burst_master.sv
// AXI4 read master: one outstanding single/INCR/WRAP read, streams beats with
// backpressure and assembles the burst into a line buffer for cache refill.
module axi_rd_burst_master
  import axi_rd_burst_master_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int ADDR_W    = 64,
  parameter int ID_W      = 4,
  parameter int MAX_BEATS = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [ID_W-1:0]             req_id,
  input  logic [ADDR_W-1:0]           req_addr,
  input  logic [AXI_LEN_W-1:0]        req_len,
  input  logic [AXI_SIZE_W-1:0]       req_size,
  input  logic                        req_wrap,
  output logic                        beat_valid,
  input  logic                        beat_ready,
  output logic [DATA_W-1:0]           beat_data,
  output logic                        beat_last,
  output logic                        line_valid,
  output logic [MAX_BEATS*DATA_W-1:0] line_data,
  output logic [AXI_RESP_W-1:0]       line_resp,
  output logic                        m_arvalid,
  input  logic                        m_arready,
  output logic [ID_W-1:0]             m_arid,
  output logic [ADDR_W-1:0]           m_araddr,
  output logic [AXI_LEN_W-1:0]        m_arlen,
  output logic [AXI_SIZE_W-1:0]       m_arsize,
  output logic [AXI_BURST_W-1:0]      m_arburst,
  output logic [AXI_PROT_W-1:0]       m_arprot,
  output logic [AXI_CACHE_W-1:0]      m_arcache,
  output logic [AXI_QOS_W-1:0]        m_arqos,
  output logic [AXI_REGION_W-1:0]     m_arregion,
  output logic                        m_arlock,
  output logic [AXI_USER_W-1:0]       m_aruser,
  input  logic                        m_rvalid,
  output logic                        m_rready,
  input  logic [ID_W-1:0]             m_rid,
  input  logic [DATA_W-1:0]           m_rdata,
  input  logic [AXI_RESP_W-1:0]       m_rresp,
  input  logic                        m_rlast
);

  localparam int OFF_W  = $clog2(DATA_W / 8);
  localparam int SLOT_W = $clog2(MAX_BEATS);
  localparam int LINE_W = MAX_BEATS * DATA_W;
  localparam logic [AXI_SIZE_W-1:0] FULL_SIZE = AXI_SIZE_W'(OFF_W);

  rd_state_e              state_q, state_d;
  logic [ID_W-1:0]        arid_q, arid_d;
  logic [ADDR_W-1:0]      araddr_q, araddr_d;
  logic [AXI_LEN_W-1:0]   arlen_q, arlen_d;
  logic [AXI_SIZE_W-1:0]  arsize_q, arsize_d;
  logic [AXI_BURST_W-1:0] arburst_q, arburst_d;
  logic [SLOT_W-1:0]      beat_cnt_q, beat_cnt_d;
  logic [AXI_RESP_W-1:0]  resp_acc_q, resp_acc_d;
  logic                   beat_valid_q, beat_valid_d;
  logic [DATA_W-1:0]      beat_data_q, beat_data_d;
  logic                   beat_last_q, beat_last_d;
  logic                   line_valid_q, line_valid_d;
  logic [LINE_W-1:0]      line_data_q, line_data_d;
  logic [AXI_RESP_W-1:0]  line_resp_q, line_resp_d;

  logic                   m_rready_s;
  logic                   r_hs_s;
  logic                   last_idx_s;
  logic                   close_s;
  logic                   proto_err_s;
  logic [AXI_RESP_W-1:0]  beat_resp_s;
  logic [AXI_RESP_W-1:0]  resp_next_s;
  logic [AXI_SIZE_W-1:0]  size_eff_s;
  logic [ADDR_W-1:0]      align_mask_s;
  logic [DATA_W-1:0]      beat_word_s;
  logic [SLOT_W-1:0]      slot_s;

  axi_rd_beat_extract #(
    .DATA_W    (DATA_W),
    .MAX_BEATS (MAX_BEATS)
  ) u_extract (
    .rdata      (m_rdata),
    .byte_off   (araddr_q[OFF_W-1:0]),
    .size       (arsize_q),
    .wrap       (arburst_q == AXI_BURST_WRAP),
    .start_slot (araddr_q[OFF_W +: SLOT_W]),
    .beat_idx   (beat_cnt_q),
    .len        (arlen_q[SLOT_W-1:0]),
    .data       (beat_word_s),
    .slot       (slot_s)
  );

  // R-beat handshake and burst-termination decode; protocol violations fold into SLVERR.
  always_comb begin
    m_rready_s   = (state_q == ST_DATA) && (!beat_valid_q || beat_ready);
    r_hs_s       = m_rvalid && m_rready_s;
    last_idx_s   = (AXI_LEN_W'(beat_cnt_q) == arlen_q);
    close_s      = m_rlast || last_idx_s;
    proto_err_s  = (m_rid != arid_q) || (m_rlast != last_idx_s);
    beat_resp_s  = proto_err_s ? resp_max(m_rresp, AXI_RESP_SLVERR) : m_rresp;
    resp_next_s  = resp_max(resp_acc_q, beat_resp_s);
    size_eff_s   = (req_len == 8'd0) ? req_size : FULL_SIZE;
    align_mask_s = ~((ADDR_W'(1'b1) << size_eff_s) - ADDR_W'(1'b1));
  end

  // Next-state, request latch, beat output register and line assembly.
  always_comb begin
    state_d      = state_q;
    arid_d       = arid_q;
    araddr_d     = araddr_q;
    arlen_d      = arlen_q;
    arsize_d     = arsize_q;
    arburst_d    = arburst_q;
    beat_cnt_d   = beat_cnt_q;
    resp_acc_d   = resp_acc_q;
    beat_valid_d = beat_valid_q;
    beat_data_d  = beat_data_q;
    beat_last_d  = beat_last_q;
    line_valid_d = 1'b0;
    line_data_d  = line_data_q;
    line_resp_d  = line_resp_q;

    if (r_hs_s) begin
      beat_valid_d = 1'b1;
      beat_data_d  = beat_word_s;
      beat_last_d  = close_s;
      if (beat_cnt_q == {SLOT_W{1'b0}}) begin
        line_data_d = {LINE_W{1'b0}};
      end else begin
        line_data_d = line_data_q;
      end
      line_data_d[slot_s*DATA_W +: DATA_W] = beat_word_s;
    end else if (beat_ready) begin
      beat_valid_d = 1'b0;
      beat_last_d  = 1'b0;
    end else begin
      beat_valid_d = beat_valid_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          arid_d     = req_id;
          araddr_d   = req_addr & align_mask_s;
          arlen_d    = req_len;
          arsize_d   = size_eff_s;
          arburst_d  = req_wrap ? AXI_BURST_WRAP : AXI_BURST_INCR;
          beat_cnt_d = {SLOT_W{1'b0}};
          resp_acc_d = AXI_RESP_OKAY;
          state_d    = ST_ADDR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (m_arready) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (r_hs_s) begin
          beat_cnt_d = beat_cnt_q + SLOT_W'(1'b1);
          resp_acc_d = resp_next_s;
          if (close_s) begin
            line_valid_d = 1'b1;
            line_resp_d  = resp_next_s;
            state_d      = ST_DONE;
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          state_d = ST_DATA;
        end
      end
      ST_DONE: begin
        if (!beat_valid_d) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      arid_q       <= {ID_W{1'b0}};
      araddr_q     <= {ADDR_W{1'b0}};
      arlen_q      <= {AXI_LEN_W{1'b0}};
      arsize_q     <= {AXI_SIZE_W{1'b0}};
      arburst_q    <= {AXI_BURST_W{1'b0}};
      beat_cnt_q   <= {SLOT_W{1'b0}};
      resp_acc_q   <= AXI_RESP_OKAY;
      beat_valid_q <= 1'b0;
      beat_data_q  <= {DATA_W{1'b0}};
      beat_last_q  <= 1'b0;
      line_valid_q <= 1'b0;
      line_data_q  <= {LINE_W{1'b0}};
      line_resp_q  <= AXI_RESP_OKAY;
    end else begin
      state_q      <= state_d;
      arid_q       <= arid_d;
      araddr_q     <= araddr_d;
      arlen_q      <= arlen_d;
      arsize_q     <= arsize_d;
      arburst_q    <= arburst_d;
      beat_cnt_q   <= beat_cnt_d;
      resp_acc_q   <= resp_acc_d;
      beat_valid_q <= beat_valid_d;
      beat_data_q  <= beat_data_d;
      beat_last_q  <= beat_last_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      line_resp_q  <= line_resp_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign m_arvalid  = (state_q == ST_ADDR);
  assign m_arid     = arid_q;
  assign m_araddr   = araddr_q;
  assign m_arlen    = arlen_q;
  assign m_arsize   = arsize_q;
  assign m_arburst  = arburst_q;
  assign m_arprot   = {AXI_PROT_W{1'b0}};
  assign m_arcache  = {AXI_CACHE_W{1'b0}};
  assign m_arqos    = {AXI_QOS_W{1'b0}};
  assign m_arregion = {AXI_REGION_W{1'b0}};
  assign m_arlock   = 1'b0;
  assign m_aruser   = {AXI_USER_W{1'b0}};
  assign m_rready   = m_rready_s;
  assign beat_valid = beat_valid_q;
  assign beat_data  = beat_data_q;
  assign beat_last  = beat_last_q;
  assign line_valid = line_valid_q;
  assign line_data  = line_data_q;
  assign line_resp  = line_resp_q;

endmodule
